// File: rtl/nsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nsu_pkg
// Description : Shared size encodings, result record and narrowing function
//               for the narrow store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package nsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ovf;
        logic        misalign;
    } nsu_result_t;

    localparam int c_RESULT_W = $bits(nsu_result_t);

    // Misaligned/illegal accesses leave every result field at zero.
    function automatic nsu_result_t narrow_result(
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic        is_signed,
        input logic [1:0]  addr
    );
        nsu_result_t r;
        logic [4:0]  sh;
        r  = '0;
        sh = {addr, 3'b000};
        case (size_e'(size))
            SZ_BYTE: begin
                r.wdata = {24'd0, data[7:0]} << sh;
                r.be    = 4'b0001 << addr;
                r.ovf   = is_signed ? !((&data[31:7]) || (~|data[31:7]))
                                    : (|data[31:8]);
            end
            SZ_HALF: begin
                if (!addr[0]) begin
                    r.wdata = {16'd0, data[15:0]} << sh;
                    r.be    = 4'b0011 << addr;
                    r.ovf   = is_signed ? !((&data[31:15]) || (~|data[31:15]))
                                        : (|data[31:16]);
                end else begin
                    r.misalign = 1'b1;
                end
            end
            SZ_WORD: begin
                if (addr == 2'b00) begin
                    r.wdata = data;
                    r.be    = 4'b1111;
                end else begin
                    r.misalign = 1'b1;
                end
            end
            default: r.misalign = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry FIFO buffer with registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = (r_count != 2'd0) & out_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    // Zero the outputs while empty so stale entries never appear downstream.
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/narrow_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : narrow_store_unit
// Description : Narrows a 32-bit store value to byte/half/word lanes, flags
//               overflow and misalignment, and counts delivered overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module narrow_store_unit
    import nsu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    input  logic [1:0]       in_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_wdata,
    output logic [3:0]       out_be,
    output logic             out_ovf,
    output logic             out_misalign,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    nsu_result_t      w_req_result;
    nsu_result_t      w_out_result;
    logic             w_ovf_delivered;
    logic [CNT_W-1:0] r_ovf_count;

    assign w_req_result = narrow_result(in_data, in_size, in_signed, in_addr);

    skid_buf2 #(
        .WIDTH(c_RESULT_W)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_req_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out_result)
    );

    assign out_wdata    = w_out_result.wdata;
    assign out_be       = w_out_result.be;
    assign out_ovf      = w_out_result.ovf;
    assign out_misalign = w_out_result.misalign;

    assign w_ovf_delivered = out_valid & out_ready & w_out_result.ovf;

    // Clear has priority over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf_count <= '0;
        end else if (clr_count) begin
            r_ovf_count <= '0;
        end else if (w_ovf_delivered && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: doc/narrow_store_unit.md
NARROW_STORE_UNIT -- requirements
Module: narrow_store_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of the overflow event counter.
REQ-002 Port: clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port: reset_n, input, 1, reset; synchronous, active-low.
REQ-004 Port: in_valid, input, 1, an upstream request is present.
REQ-005 Port: in_ready, output, 1, the unit accepts a request this cycle.
REQ-006 Port: in_data, input, 32, register value to be narrowed.
REQ-007 Port: in_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port: in_signed, input, 1, 1 = signed range check, 0 = unsigned range check.
REQ-009 Port: in_addr, input, 2, low byte-address bits of the access.
REQ-010 Port: out_valid, output, 1, a result is present.
REQ-011 Port: out_ready, input, 1, downstream accepts the result.
REQ-012 Port: out_wdata, output, 32, truncated value placed in its byte lane(s).
REQ-013 Port: out_be, output, 4, byte enables.
REQ-014 Port: out_ovf, output, 1, value not representable in the access size.
REQ-015 Port: out_misalign, output, 1, misaligned or illegal access.
REQ-016 Port: clr_count, input, 1, synchronous clear of ovf_count.
REQ-017 Port: ovf_count, output, CNT_W, saturating count of delivered overflow results.

Function
REQ-018 Transfers occur only on valid&ready; a result is computed combinationally from the accepted inputs and stored in a 2-entry buffer.
REQ-019 Latency is 1 cycle: a request accepted in cycle N into an empty buffer gives out_valid=1 in cycle N+1.
REQ-020 in_ready = (entries < 2), registered, with no combinational path from out_ready.
REQ-021 A push and a pop in the same cycle leave the entry count unchanged; order is strictly FIFO.
REQ-022 While out_valid=1 and out_ready=0, all out_* signals are held stable.
REQ-023 Overflow is decided as follows:
- signed byte: ovf unless in_data[31:7] are all equal;
- unsigned byte: ovf unless in_data[31:8]=0;
- signed half: ovf unless in_data[31:15] are all equal;
- unsigned half: ovf unless in_data[31:16]=0;
- word: never ovf.
REQ-024 Byte: out_wdata = in_data[7:0] shifted left by 8*in_addr; other lanes 0; out_be = 0001 << in_addr.
REQ-025 Half: if in_addr[0]=0, out_wdata = in_data[15:0] shifted left by 8*in_addr and out_be = 0011 << in_addr; otherwise the access is misaligned.
REQ-026 Word: if in_addr=00, out_wdata = in_data and out_be = 1111; otherwise the access is misaligned.
REQ-027 A misaligned access or in_size=11 gives out_misalign=1, out_be=0000, out_wdata=0, out_ovf=0.
REQ-028 When data is truncated, out_wdata still carries the truncated bits and out_be is normal; out_ovf=1 flags the loss.
REQ-029 ovf_count increments by 1 on each output handshake with out_ovf=1, and saturates at all-ones.
REQ-030 clr_count sets ovf_count to 0 next cycle; clear wins over a simultaneous increment.

Reset
REQ-031 While reset_n=0 at a clock edge:
- buffer emptied;
- out_valid=0, in_ready=0;
- out_wdata=0, out_be=0, out_ovf=0, out_misalign=0;
- ovf_count=0.
REQ-032 in_ready rises in the first cycle after reset_n returns to 1.
REQ-033 Reset mid-operation discards buffered entries, with no output handshake for them.

Structure
REQ-034 The size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL) and the result record type (wdata, be, ovf, misalign) live in the shared package nsu_pkg.
REQ-035 The 2-entry buffer is the sub-module skid_buf2, parameterised by payload width.

Verification
REQ-036 Request unsigned byte, data 0x000000AB, addr 10, out_ready=1 -> next cycle: out_wdata=0x00AB0000, be=0100, ovf=0.
REQ-037 Request signed half, data 0xFFFF8000, addr 00 -> wdata=0x00008000, be=0011, ovf=0; then data 0x00008000 -> ovf=1, ovf_count=1.
REQ-038 Request half at addr 01, and word at addr 10 -> misalign=1, be=0000, wdata=0, ovf_count unchanged.
REQ-039 Hold out_ready=0 and push 3 requests -> in_ready=0 after 2 are accepted, output stable; then out_ready=1 -> both delivered in order, in_ready=1 again.
REQ-040 Force ovf_count to all-ones, deliver an ovf result -> stays all-ones; assert clr_count together with an ovf handshake -> 0.
REQ-041 Pull reset_n=0 with 2 entries buffered -> out_valid=0 next cycle, no handshake; in_ready=1 one cycle after release.
